// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin scheduler sharing one 32-bit zero-fill left
// barrel shifter among NREQ requesters. The granted operand is captured,
// shifted for one cycle, and the result is held under valid/ready with the
// owner's requester ID.
module shift_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   in_bus,
    input  logic [NREQ*5-1:0]    amt_bus,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [31:0]     op_q, op_d;
    logic [4:0]      amt_q, amt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic            out_valid_q, out_valid_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  grant_probe;
    logic [31:0]     shift_v;

    // Rotating priority search: first set req bit at or above ptr, wrapping.
    // NREQ is a power of two, so IDW-bit addition wraps modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_probe = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_probe = ptr_q + IDW'(i);
            if (!grant_found && req[grant_probe]) begin
                grant_found = 1'b1;
                grant_idx   = grant_probe;
            end
        end
    end

    // Logarithmic left barrel shifter; zeros enter at bit 0, overflow is lost.
    always_comb begin
        shift_v = op_q;
        for (int unsigned s = 0; s < 5; s++) begin
            if (amt_q[s]) begin
                shift_v = shift_v << (32'd1 << s);
            end
        end
    end

    // Next-state and datapath register updates for IDLE -> SHIFT -> HOLD.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        amt_d       = amt_q;
        id_d        = id_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_d    = in_bus[32*grant_idx +: 32];
                    amt_d   = amt_bus[5*grant_idx +: 5];
                    id_d    = grant_idx;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_data_d  = shift_v;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                ptr_d       = id_q + 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_q        <= '0;
            amt_q       <= '0;
            id_q        <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            id_q        <= id_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ack and busy decode purely from registered state (no path from req).
    always_comb begin
        ack = '0;
        if (state_q == SHIFT) begin
            ack[id_q] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;

endmodule
